// File: rtl/router_fsm.sv
// Router control FSM: decodes the header address, sequences payload/parity
// loads into the addressed output FIFO and stalls while that FIFO is full.
module router_fsm (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_packet_valid,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg,
  output logic       busy
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL,
    LOAD_PARITY,
    CHECK_PARITY_ERROR,
    WAIT_TILL_EMPTY
  } state_t;

  state_t     state, next_state;
  logic [1:0] addr_reg;
  logic       hdr_empty;
  logic       addr_empty;
  logic       addr_soft_reset;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= DECODE_ADDRESS;
      addr_reg <= 2'b11;
    end else begin
      state <= next_state;
      if (state == DECODE_ADDRESS && pkt_valid)
        addr_reg <= data_in;
    end
  end

  // Address 3 selects no FIFO: it is never empty and never soft-reset.
  always_comb begin
    hdr_empty = 1'b0;
    case (data_in)
      2'd0:    hdr_empty = fifo_empty_0;
      2'd1:    hdr_empty = fifo_empty_1;
      2'd2:    hdr_empty = fifo_empty_2;
      default: hdr_empty = 1'b0;
    endcase
  end

  always_comb begin
    addr_empty      = 1'b0;
    addr_soft_reset = 1'b0;
    case (addr_reg)
      2'd0:    begin addr_empty = fifo_empty_0; addr_soft_reset = soft_reset_0; end
      2'd1:    begin addr_empty = fifo_empty_1; addr_soft_reset = soft_reset_1; end
      2'd2:    begin addr_empty = fifo_empty_2; addr_soft_reset = soft_reset_2; end
      default: begin addr_empty = 1'b0;         addr_soft_reset = 1'b0;         end
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      DECODE_ADDRESS:
        if (pkt_valid && data_in != 2'b11)
          next_state = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
      LOAD_FIRST_DATA:
        next_state = LOAD_DATA;
      LOAD_DATA:
        if (fifo_full)       next_state = FIFO_FULL_STATE;
        else if (!pkt_valid) next_state = LOAD_PARITY;
      FIFO_FULL_STATE:
        if (!fifo_full) next_state = LOAD_AFTER_FULL;
      LOAD_AFTER_FULL:
        if (parity_done)           next_state = DECODE_ADDRESS;
        else if (low_packet_valid) next_state = LOAD_PARITY;
        else                       next_state = LOAD_DATA;
      LOAD_PARITY:
        next_state = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR:
        next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      WAIT_TILL_EMPTY:
        if (addr_reg == 2'b11) next_state = DECODE_ADDRESS;
        else if (addr_empty)   next_state = LOAD_FIRST_DATA;
      default:
        next_state = DECODE_ADDRESS;
    endcase
    if (addr_soft_reset)
      next_state = DECODE_ADDRESS;
  end

  always_comb begin
    detect_add    = (state == DECODE_ADDRESS);
    lfd_state     = (state == LOAD_FIRST_DATA);
    ld_state      = (state == LOAD_DATA);
    laf_state     = (state == LOAD_AFTER_FULL);
    full_state    = (state == FIFO_FULL_STATE);
    write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) ||
                    (state == LOAD_AFTER_FULL);
    rst_int_reg   = (state == CHECK_PARITY_ERROR);
    busy          = !((state == DECODE_ADDRESS) || (state == LOAD_DATA));
  end

endmodule

// File: tb/tb_router_fsm.sv
// Bench for router_fsm: rule-level reference model checked every cycle,
// plus directed scenarios with literal output expectations.
module tb_router_fsm;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       pkt_valid = 1'b0;
  logic [1:0] data_in = 2'b00;
  logic       fifo_full = 1'b0;
  logic       fifo_empty_0 = 1'b1, fifo_empty_1 = 1'b1, fifo_empty_2 = 1'b1;
  logic       soft_reset_0 = 1'b0, soft_reset_1 = 1'b0, soft_reset_2 = 1'b0;
  logic       parity_done = 1'b0;
  logic       low_packet_valid = 1'b0;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       write_enb_reg, rst_int_reg, busy;

  int checks = 0;
  int passed = 0;

  router_fsm dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1),
    .fifo_empty_2(fifo_empty_2), .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1),
    .soft_reset_2(soft_reset_2), .parity_done(parity_done), .low_packet_valid(low_packet_valid),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
    .full_state(full_state), .write_enb_reg(write_enb_reg), .rst_int_reg(rst_int_reg), .busy(busy)
  );

  always #5 clock = ~clock;

  // Output vector order: {detect_add, lfd, ld, laf, full, write_enb, rst_int, busy}
  localparam logic [7:0] O_DA  = 8'b1000_0000;
  localparam logic [7:0] O_LFD = 8'b0100_0001;
  localparam logic [7:0] O_LD  = 8'b0010_0100;
  localparam logic [7:0] O_FFS = 8'b0000_1001;
  localparam logic [7:0] O_LAF = 8'b0001_0101;
  localparam logic [7:0] O_LP  = 8'b0000_0101;
  localparam logic [7:0] O_CPE = 8'b0000_0011;
  localparam logic [7:0] O_WTE = 8'b0000_0001;

  logic [7:0] dut_out;
  assign dut_out = {detect_add, lfd_state, ld_state, laf_state, full_state,
                    write_enb_reg, rst_int_reg, busy};

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  // Reference model: packet-flow rules applied to a named phase.
  typedef enum {M_DA, M_LFD, M_LD, M_FFS, M_LAF, M_LP, M_CPE, M_WTE} phase_t;
  phase_t     m_phase = M_DA;
  logic [1:0] m_addr = 2'b11;

  function automatic logic sel(input logic [2:0] v, input logic [1:0] a);
    return |((v >> a) & 3'b001);
  endfunction

  function automatic logic [7:0] phase_out(input phase_t p);
    case (p)
      M_DA:    return O_DA;
      M_LFD:   return O_LFD;
      M_LD:    return O_LD;
      M_FFS:   return O_FFS;
      M_LAF:   return O_LAF;
      M_LP:    return O_LP;
      M_CPE:   return O_CPE;
      default: return O_WTE;
    endcase
  endfunction

  function automatic phase_t rule_next(input phase_t p, input logic [1:0] a);
    logic [2:0] empt, sr;
    empt = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
    sr   = {soft_reset_2, soft_reset_1, soft_reset_0};
    if (sel(sr, a)) return M_DA;
    case (p)
      M_DA: begin
        if (!pkt_valid || data_in == 2'd3) return M_DA;
        return sel(empt, data_in) ? M_LFD : M_WTE;
      end
      M_LFD: return M_LD;
      M_LD:  return fifo_full ? M_FFS : (pkt_valid ? M_LD : M_LP);
      M_FFS: return fifo_full ? M_FFS : M_LAF;
      M_LAF: return parity_done ? M_DA : (low_packet_valid ? M_LP : M_LD);
      M_LP:  return M_CPE;
      M_CPE: return fifo_full ? M_FFS : M_DA;
      default: begin
        if (a == 2'd3) return M_DA;
        return sel(empt, a) ? M_LFD : M_WTE;
      end
    endcase
  endfunction

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_phase <= M_DA;
      m_addr  <= 2'b11;
    end else begin
      m_phase <= rule_next(m_phase, m_addr);
      if (m_phase == M_DA && pkt_valid) m_addr <= data_in;
    end
  end

  always @(negedge clock) chk("model", dut_out, phase_out(m_phase));

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic step(input string name, input logic [7:0] e);
    tick();
    chk(name, dut_out, e);
  endtask

  logic [7:0] seq [8];
  int wen_cnt, rst_cnt;

  initial begin
    // Reset held through a clock edge
    tick();
    chk("reset_out", dut_out, O_DA);
    resetn = 1'b1;
    step("idle_da", O_DA);
    step("idle_da2", O_DA);

    // Normal packet to port 1 with four payload cycles
    seq = '{O_LFD, O_LD, O_LD, O_LD, O_LD, O_LP, O_CPE, O_DA};
    wen_cnt = 0; rst_cnt = 0;
    pkt_valid = 1'b1; data_in = 2'd1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("norm_%0d", i), dut_out, seq[i]);
      if (write_enb_reg) wen_cnt++;
      if (rst_int_reg) rst_cnt++;
      if (i == 0) data_in = 2'd2;
      if (i == 4) pkt_valid = 1'b0;
    end
    chk("norm_wen_cycles", 8'(wen_cnt), 8'd5);
    chk("norm_rst_cycles", 8'(rst_cnt), 8'd1);

    // Busy FIFO 2, then full stall, then full on parity check
    pkt_valid = 1'b1; data_in = 2'd2; fifo_empty_2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step($sformatf("wte_%0d", i), O_WTE);
      data_in = 2'd0;
    end
    fifo_empty_2 = 1'b1;
    step("wte_lfd", O_LFD);
    step("wte_ld", O_LD);
    fifo_full = 1'b1;
    step("full_0", O_FFS);
    step("full_1", O_FFS);
    step("full_2", O_FFS);
    fifo_full = 1'b0;
    step("full_laf", O_LAF);
    step("full_ld", O_LD);
    pkt_valid = 1'b0;
    step("end_lp", O_LP);
    step("end_cpe", O_CPE);
    fifo_full = 1'b1;
    step("end_ffs", O_FFS);
    fifo_full = 1'b0; parity_done = 1'b1;
    step("end_laf", O_LAF);
    step("end_da", O_DA);
    parity_done = 1'b0;

    // Soft reset: non-addressed FIFO ignored, addressed FIFO aborts
    pkt_valid = 1'b1; data_in = 2'd0;
    step("sr_lfd", O_LFD);
    step("sr_ld", O_LD);
    soft_reset_1 = 1'b1;
    step("sr_other", O_LD);
    soft_reset_1 = 1'b0; soft_reset_0 = 1'b1;
    step("sr_own", O_DA);
    soft_reset_0 = 1'b0; pkt_valid = 1'b0;
    step("sr_idle", O_DA);

    // Stall resolved by low_packet_valid goes straight to parity
    pkt_valid = 1'b1; data_in = 2'd0;
    step("low_lfd", O_LFD);
    step("low_ld", O_LD);
    fifo_full = 1'b1;
    step("low_ffs", O_FFS);
    fifo_full = 1'b0; low_packet_valid = 1'b1;
    step("low_laf", O_LAF);
    step("low_lp", O_LP);
    low_packet_valid = 1'b0; pkt_valid = 1'b0;
    step("low_cpe", O_CPE);
    step("low_da", O_DA);

    // Asynchronous reset mid-cycle while stalled
    pkt_valid = 1'b1; data_in = 2'd1;
    step("ar_lfd", O_LFD);
    step("ar_ld", O_LD);
    fifo_full = 1'b1;
    step("ar_ffs", O_FFS);
    #2 resetn = 1'b0;
    #1 chk("ar_async", dut_out, O_DA);
    chk("ar_full_low", {7'b0, full_state}, 8'd0);
    tick();
    resetn = 1'b1; fifo_full = 1'b0; data_in = 2'd3; pkt_valid = 1'b1;
    step("ar_inv_hdr", O_DA);
    soft_reset_0 = 1'b1;
    step("ar_inv_hdr2", O_DA);
    soft_reset_0 = 1'b0; pkt_valid = 1'b0;
    step("ar_idle", O_DA);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
